// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state type and oversample constants for the UART receiver
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;
  localparam logic [3:0] VOTE_LO  = 4'd7;
  localparam logic [3:0] VOTE_MID = 4'd8;
  localparam logic [3:0] VOTE_HI  = 4'd9;
  localparam int         OVERSAMPLE_DEF = 16;
  localparam logic [3:0] SMP_LAST = 4'(OVERSAMPLE_DEF - 1);
endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: 2-FF rx synchroniser and rxclk rising-edge detector
// Ports: clk, reset_n (async active-low), rxclk (16x oversample wave),
//        rx (async serial line) -> rx_s (synchronised rx), tick (1-cycle sample enable)
module uart_rx_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic rxclk,
  input  logic rx,
  output logic rx_s,
  output logic tick
);
  logic [1:0] rx_q;
  logic       rxclk_q;
  // synchroniser presets to the idle-high line level so reset never fakes a start bit edge
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      rx_q    <= 2'b11;
      rxclk_q <= 1'b0;
    end else begin
      rx_q    <= {rx_q[0], rx};
      rxclk_q <= rxclk;
    end
  assign rx_s = rx_q[1];
  assign tick = rxclk & ~rxclk_q;
endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver with 3-sample majority vote per bit
// Ports: clk, reset_n (async active-low), rxclk (oversample wave from baud gen), rx (serial in)
//        rx_data (last payload), rx_valid / frame_err (1-cycle strobes), busy (FSM not idle)
//        parity_err (1-cycle strobe) exists only when UART_RX_PARITY_EN is defined
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
`ifdef UART_RX_PARITY_EN
  , parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 rxclk,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
`ifdef UART_RX_PARITY_EN
  output logic                 parity_err,
`endif
  output logic                 busy
);
  localparam int         BW      = DATA_BITS > 1 ? $clog2(DATA_BITS) : 1;
  localparam logic [3:0] SMP_END = 4'(OVERSAMPLE - 1);
  logic rx_s, tick, vote, vote_at, last;
  rx_state_t state_q, state_d;
  logic [3:0] smp_q, smp_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [1:0] v_q, v_d;
  logic [DATA_BITS-1:0] sh_q, sh_d, data_q, data_d;
  logic valid_q, valid_d, ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
  logic par_q, par_d, perr_q, perr_d;
`endif
  uart_rx_sync u_sync (.clk(clk), .reset_n(reset_n), .rxclk(rxclk), .rx(rx), .rx_s(rx_s), .tick(tick));
  // samples 7 and 8 are held; sample 9 is taken live so the vote resolves on that tick
  assign vote    = (v_q[0] & v_q[1]) | (v_q[0] & rx_s) | (v_q[1] & rx_s);
  assign vote_at = tick && smp_q == VOTE_HI;
  assign last    = tick && smp_q == SMP_END;
  assign v_d     = {tick && smp_q == VOTE_MID ? rx_s : v_q[1], tick && smp_q == VOTE_LO ? rx_s : v_q[0]};
  always_comb begin
    state_d = state_q;
    smp_d   = tick ? (smp_q == SMP_END ? '0 : smp_q + 4'd1) : smp_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
    perr_d  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        smp_d   = '0;
        state_d = tick && !rx_s ? START : IDLE;
      end
      START: begin
        if (vote_at && vote) state_d = IDLE;
        else if (last) begin
          state_d = DATA;
          bit_d   = '0;
        end
      end
      DATA: begin
        if (vote_at) sh_d = {vote, sh_q[DATA_BITS-1:1]};
        if (last) begin
          bit_d = bit_q + 1'b1;
`ifdef UART_RX_PARITY_EN
          state_d = bit_q == BW'(DATA_BITS - 1) ? PARITY : DATA;
`else
          state_d = bit_q == BW'(DATA_BITS - 1) ? STOP : DATA;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (vote_at) par_d = vote;
        if (last) state_d = STOP;
      end
`endif
      STOP: begin
        // return to IDLE on the vote tick so a start bit half a bit later is still caught
        if (vote_at) begin
          state_d = IDLE;
          data_d  = sh_q;
          valid_d = vote;
          ferr_d  = !vote;
`ifdef UART_RX_PARITY_EN
          perr_d  = (^sh_q ^ par_q) != PARITY_ODD;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      smp_q   <= '0;
      bit_q   <= '0;
      v_q     <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      smp_q   <= smp_d;
      bit_q   <= bit_d;
      v_q     <= v_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
      perr_q  <= perr_d;
`endif
    end
  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = perr_q;
`endif
  assign busy = state_q != IDLE;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: table-driven scoreboard bench for uart_rx
module tb_uart_rx;
  localparam int RXP  = 27;
  localparam int BITP = 16 * RXP;
  localparam bit PODD = 1'b0;
`ifdef UART_RX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  typedef struct {logic [7:0] data; logic valid; logic ferr; logic perr;} exp_t;
  typedef struct {logic [7:0] data; logic stop; logic flip; logic idle; logic exp_valid; logic exp_ferr;} vec_t;
  logic clk = 1'b0, reset_n = 1'b0, rxclk = 1'b0, rx = 1'b1;
  logic [7:0] rx_data;
  logic rx_valid, frame_err, busy;
`ifdef UART_RX_PARITY_EN
  logic parity_err;
`endif
  int checks = 0, failures = 0;
  exp_t sb[$];
  exp_t e;
  longint cyc = 0, t_prev = 0, t_last = 0;
  logic strobe_prev = 1'b0;
  vec_t vt[6];
  uart_rx #(
    .DATA_BITS(8), .OVERSAMPLE(16)
`ifdef UART_RX_PARITY_EN
    , .PARITY_ODD(PODD)
`endif
  ) dut (
    .clk(clk), .reset_n(reset_n), .rxclk(rxclk), .rx(rx),
    .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err),
`ifdef UART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .busy(busy)
  );
  always #5 clk = ~clk;
  initial forever begin
    repeat (13) @(negedge clk);
    rxclk = 1'b0;
    repeat (14) @(negedge clk);
    rxclk = 1'b1;
  end
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    if (rx_valid | frame_err) begin
      chk("strobe_width", {31'd0, strobe_prev}, 0);
      chk("strobe_exclusive", {31'd0, rx_valid & frame_err}, 0);
      if (sb.size() == 0) chk("unexpected_strobe", {30'd0, rx_valid, frame_err}, 0);
      else begin
        e = sb.pop_front();
        chk("rx_data", {24'd0, rx_data}, {24'd0, e.data});
        chk("rx_valid", {31'd0, rx_valid}, {31'd0, e.valid});
        chk("frame_err", {31'd0, frame_err}, {31'd0, e.ferr});
`ifdef UART_RX_PARITY_EN
        chk("parity_err", {31'd0, parity_err}, {31'd0, e.perr});
`endif
      end
      if (rx_valid) begin
        t_prev = t_last;
        t_last = cyc;
      end
    end
    strobe_prev = rx_valid | frame_err;
  end
  task automatic drive(input logic b, input int n);
    rx = b;
    repeat (n) @(negedge clk);
  endtask
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic flip);
    drive(1'b0, BITP);
    for (int i = 0; i < 8; i++) drive(d[i], BITP);
`ifdef UART_RX_PARITY_EN
    drive(^d ^ PODD ^ flip, BITP);
`endif
    drive(stop, BITP);
  endtask
  task automatic wait_empty(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk(name, sb.size(), 0);
  endtask
  task automatic frame(input logic [7:0] d, input logic stop, input logic flip, input logic idle);
    sb.push_back('{data: d, valid: stop, ferr: !stop, perr: flip});
    send_frame(d, stop, flip);
    if (idle) drive(1'b1, BITP);
    wait_empty("strobe_seen");
    if (idle) chk("busy_idle", {31'd0, busy}, 0);
  endtask
  initial begin
    #900us;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [7:0] d;
    logic gap_ok;
    vt[0] = '{8'hA5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    vt[1] = '{8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vt[2] = '{8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[3] = '{8'hFF, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    vt[4] = '{8'h01, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    vt[5] = '{8'h01, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    repeat (3) @(negedge clk);
    chk("rst_rx_data", {24'd0, rx_data}, 0);
    chk("rst_rx_valid", {31'd0, rx_valid}, 0);
    chk("rst_frame_err", {31'd0, frame_err}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    reset_n = 1'b1;
    drive(1'b1, BITP);
    for (int i = 0; i < 6; i++) begin
      sb.push_back('{data: vt[i].data, valid: vt[i].exp_valid, ferr: vt[i].exp_ferr, perr: vt[i].flip});
      send_frame(vt[i].data, vt[i].stop, vt[i].flip);
      if (vt[i].idle) drive(1'b1, BITP);
      wait_empty("vec_strobe_seen");
      if (vt[i].idle) chk("vec_busy_idle", {31'd0, busy}, 0);
      if (i == 3) begin
        gap_ok = (t_last - t_prev >= longint'(FB * BITP - RXP)) && (t_last - t_prev <= longint'(FB * BITP + RXP));
        chk("b2b_gap", {31'd0, gap_ok}, 1);
      end
    end
    drive(1'b0, 4 * RXP);
    drive(1'b1, 12 * RXP);
    chk("glitch_busy", {31'd0, busy}, 0);
    drive(1'b1, BITP);
    frame(8'h3C, 1'b1, 1'b0, 1'b1);
    d = 8'h81;
    drive(1'b0, BITP);
    for (int i = 0; i < 3; i++) drive(d[i], BITP);
    drive(d[3], BITP / 2);
    reset_n = 1'b0;
    drive(d[3], 2);
    chk("midrst_rx_data", {24'd0, rx_data}, 0);
    chk("midrst_rx_valid", {31'd0, rx_valid}, 0);
    chk("midrst_frame_err", {31'd0, frame_err}, 0);
    chk("midrst_busy", {31'd0, busy}, 0);
    drive(d[3], BITP / 2 - 2);
    for (int i = 4; i < 8; i++) drive(d[i], BITP);
`ifdef UART_RX_PARITY_EN
    drive(^d ^ PODD, BITP);
`endif
    drive(1'b1, 2 * BITP);
    reset_n = 1'b1;
    drive(1'b1, BITP);
    frame(8'h5A, 1'b1, 1'b0, 1'b1);
    sb.push_back('{data: 8'h00, valid: 1'b0, ferr: 1'b1, perr: 1'b0});
    sb.push_back('{data: 8'h00, valid: 1'b0, ferr: 1'b1, perr: 1'b0});
    drive(1'b0, (2 * FB - 1) * BITP + BITP / 2);
    drive(1'b1, 2 * BITP);
    wait_empty("break_strobes");
    chk("break_busy", {31'd0, busy}, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
